ps2_mouse_rx: RTL and testbench

Receive-only PS/2 mouse front end. It synchronises and de-glitches the mouse clock and data lines and deserialises 11-bit PS/2 frames. It assembles standard 3-byte stream-mode packets and presents button state and 9-bit signed X/Y deltas with a one-cycle valid strobe. It sits directly upstream of the IO controller, which consumes decoded packets and updates the cursor/memory-mapped state. Host-to-device commands, including the 0xF4 stream-enable, belong to a separate block.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_mouse_rx_if.sv | 22 ++
 rtl/ps2_line_filter.sv | 46 ++++
 rtl/ps2_mouse_rx.sv | 185 ++++++++++++++++++
 tb/tb_ps2_mouse_rx.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: frame FSM states, frame/packet sizes, byte0 field map.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_e;

  localparam int PS2_DATA_BITS    = 8;
  localparam int PS2_PACKET_BYTES = 3;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;
  localparam int ALIGN = 3;
  localparam int XSIGN = 4;
  localparam int YSIGN = 5;
  localparam int XOVF  = 6;
  localparam int YOVF  = 7;

  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic parity_ok(input logic [PS2_DATA_BITS-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_mouse_rx_if.sv
// Raw PS/2 lines in, decoded mouse packet and error strobe out.
interface ps2_mouse_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       packet_valid;
  logic [2:0] buttons;
  logic [8:0] dx;
  logic [8:0] dy;
  logic       overflow_x;
  logic       overflow_y;
  logic       frame_error;

  modport master (
    output ps2_clk, ps2_data,
    input  packet_valid, buttons, dx, dy, overflow_x, overflow_y, frame_error
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output packet_valid, buttons, dx, dy, overflow_x, overflow_y, frame_error
  );
endinterface

// File: rtl/ps2_line_filter.sv
// 2-flop synchroniser, FILTER_LEN-deep level filter and registered falling-edge strobe.
// Raw edge to fall_o: 2 + FILTER_LEN + 1 cycles; glitches shorter than FILTER_LEN are ignored.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic fall_o
);

  logic [1:0]            sync_q, sync_d;
  logic [FILTER_LEN-1:0] shift_q, shift_d;
  logic                  level_q, level_d;
  logic                  fall_q, fall_d;

  always_comb begin
    sync_d  = {sync_q[0], raw_i};
    shift_d = {shift_q[FILTER_LEN-2:0], sync_q[1]};
    level_d = level_q;
    if (shift_q == '0) begin
      level_d = 1'b0;
    end else if (shift_q == '1) begin
      level_d = 1'b1;
    end
    fall_d = level_q & ~level_d;
  end

  // Idle PS/2 lines are high, so everything resets to ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b11;
      shift_q <= '1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      shift_q <= shift_d;
      level_q <= level_d;
      fall_q  <= fall_d;
    end
  end

  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: deserialises 11-bit frames and assembles 3-byte stream packets.
// Outputs update one cycle after the stop-bit fall of byte 2; errors pulse frame_error.
module ps2_mouse_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic          clk,
  input logic          reset,
  ps2_mouse_rx_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic clk_fall;
  logic [1:0] data_sync_q, data_sync_d;
  logic       data_s;

  frame_state_e state_q, state_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]   shreg_q, shreg_d;
  logic         par_q, par_d;
  logic [1:0]   idx_q, idx_d;
  logic [7:0]   b0_q, b0_d;
  logic [7:0]   b1_q, b1_d;
  logic [TW-1:0] cnt_q, cnt_d;

  logic [2:0] buttons_q, buttons_d;
  logic [8:0] dx_q, dx_d;
  logic [8:0] dy_q, dy_d;
  logic       ovx_q, ovx_d;
  logic       ovy_q, ovy_d;
  logic       pv_q, pv_d;
  logic       fe_q, fe_d;

  logic byte_ok;
  logic tmo_hit;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk   (clk),
    .reset (reset),
    .raw_i (bus.ps2_clk),
    .fall_o(clk_fall)
  );

  assign data_sync_d = {data_sync_q[0], bus.ps2_data};
  assign data_s      = data_sync_q[1];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    idx_d     = idx_q;
    b0_d      = b0_q;
    b1_d      = b1_q;
    cnt_d     = cnt_q;
    buttons_d = buttons_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    ovx_d     = ovx_q;
    ovy_d     = ovy_q;
    pv_d      = 1'b0;
    fe_d      = 1'b0;
    byte_ok   = 1'b0;
    tmo_hit   = 1'b0;

    if (clk_fall) begin
      cnt_d = '0;
    end else if (cnt_q != TMO_MAX) begin
      cnt_d   = cnt_q + 1'b1;
      tmo_hit = (cnt_q == TMO_LAST);
    end

    if (clk_fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shreg_d = {data_s, shreg_q[7:1]};
          if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) begin
            state_d = ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        ST_PARITY: begin
          par_d   = data_s;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          if (data_s && parity_ok(shreg_q, par_q)) begin
            byte_ok = 1'b1;
          end else begin
            fe_d  = 1'b1;
            idx_d = '0;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Byte 0 must carry the always-one alignment bit; anything else is dropped to resync.
    if (byte_ok) begin
      if (idx_q == 2'd0) begin
        if (shreg_q[ALIGN]) begin
          b0_d  = shreg_q;
          idx_d = 2'd1;
        end
      end else if (idx_q == 2'd1) begin
        b1_d  = shreg_q;
        idx_d = 2'd2;
      end else begin
        buttons_d = {b0_q[BTN_M], b0_q[BTN_R], b0_q[BTN_L]};
        dx_d      = {b0_q[XSIGN], b1_q};
        dy_d      = {b0_q[YSIGN], shreg_q};
        ovx_d     = b0_q[XOVF];
        ovy_d     = b0_q[YOVF];
        pv_d      = 1'b1;
        idx_d     = (idx_q == 2'(PS2_PACKET_BYTES - 1)) ? 2'd0 : idx_q + 1'b1;
      end
    end

    if (tmo_hit && (state_q != ST_IDLE || idx_q != 2'd0)) begin
      fe_d    = (state_q != ST_IDLE);
      state_d = ST_IDLE;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_sync_q <= 2'b11;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      idx_q       <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      cnt_q       <= '0;
      buttons_q   <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      ovx_q       <= 1'b0;
      ovy_q       <= 1'b0;
      pv_q        <= 1'b0;
      fe_q        <= 1'b0;
    end else begin
      data_sync_q <= data_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      idx_q       <= idx_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      cnt_q       <= cnt_d;
      buttons_q   <= buttons_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      ovx_q       <= ovx_d;
      ovy_q       <= ovy_d;
      pv_q        <= pv_d;
      fe_q        <= fe_d;
    end
  end

  assign bus.packet_valid = pv_q;
  assign bus.buttons      = buttons_q;
  assign bus.dx           = dx_q;
  assign bus.dy           = dy_q;
  assign bus.overflow_x   = ovx_q;
  assign bus.overflow_y   = ovy_q;
  assign bus.frame_error  = fe_q;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Directed bench for ps2_mouse_rx: bit-banged PS/2 frames with hand-computed packet results.
module tb_ps2_mouse_rx;

  localparam int FL   = 8;
  localparam int TMO  = 2000;
  localparam int HALF = 30;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ps2_mouse_rx_if bus ();

  ps2_mouse_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pv_cnt = 0, fe_cnt = 0, fall_cnt = 0, both_cnt = 0;
  int last_pv_cyc = 0, last_fe_cyc = 0, stop_edge_cyc = 0;

  always @(negedge clk) begin
    if (bus.packet_valid === 1'b1) begin
      pv_cnt++;
      last_pv_cyc = cyc;
    end
    if (bus.frame_error === 1'b1) begin
      fe_cnt++;
      last_fe_cyc = cyc;
    end
    if (bus.packet_valid === 1'b1 && bus.frame_error === 1'b1) both_cnt++;
    if (dut.clk_fall === 1'b1) fall_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit: data set mid-high, clock low HALF, high HALF; optional short glitch in the high phase.
  task automatic bit_out(input logic b, input bit glitch, input bit is_stop);
    bus.ps2_data = b;
    idle(HALF / 2);
    bus.ps2_clk = 1'b0;
    if (is_stop) stop_edge_cyc = cyc;
    idle(HALF);
    bus.ps2_clk = 1'b1;
    if (glitch) begin
      idle(5);
      bus.ps2_clk = 1'b0;
      idle(3);
      bus.ps2_clk = 1'b1;
      idle(HALF / 2 - 8);
    end else begin
      idle(HALF / 2);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par = 1'b0,
                           input int glitch_bit = -1, input int nbits = 11);
    logic [10:0] frame;
    frame = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bit_out(frame[i], (i == glitch_bit), (i == 10));
    end
    bus.ps2_data = 1'b1;
    if (nbits == 11) idle(100);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  int pv0, fe0, fall0;

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    idle(5);
    reset = 1'b0;
    @(negedge clk);
    check("rst_pv",  32'(bus.packet_valid), 32'd0);
    check("rst_fe",  32'(bus.frame_error),  32'd0);
    check("rst_btn", 32'(bus.buttons),      32'd0);
    check("rst_dx",  32'(bus.dx),           32'd0);
    check("rst_dy",  32'(bus.dy),           32'd0);
    check("rst_ovx", 32'(bus.overflow_x),   32'd0);
    check("rst_ovy", 32'(bus.overflow_y),   32'd0);
    idle(50);

    // Basic packet: left button, dx=+5, dy=-5
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_packet(8'h29, 8'h05, 8'hFB);
    check("p1_pv_cnt", 32'(pv_cnt - pv0), 32'd1);
    check("p1_fe_cnt", 32'(fe_cnt - fe0), 32'd0);
    check("p1_btn", 32'(bus.buttons), 32'h1);
    check("p1_dx",  32'(bus.dx), 32'h005);
    check("p1_dy",  32'(bus.dy), 32'h1FB);
    check("p1_ovx", 32'(bus.overflow_x), 32'd0);
    check("p1_ovy", 32'(bus.overflow_y), 32'd0);
    check("p1_pv_lat", 32'(last_pv_cyc - stop_edge_cyc), 32'(FL + 4));

    // Bad parity, then a good packet
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_byte(8'h29, 1'b1);
    check("par_fe_cnt", 32'(fe_cnt - fe0), 32'd1);
    check("par_pv_cnt", 32'(pv_cnt - pv0), 32'd0);
    check("par_fe_lat", 32'(last_fe_cyc - stop_edge_cyc), 32'(FL + 4));
    send_packet(8'h0A, 8'h7F, 8'h80);
    check("par2_pv_cnt", 32'(pv_cnt - pv0), 32'd1);
    check("par2_btn", 32'(bus.buttons), 32'h2);
    check("par2_dx",  32'(bus.dx), 32'h07F);
    check("par2_dy",  32'(bus.dy), 32'h080);

    // Misaligned byte 0 is dropped silently
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_byte(8'h05);
    send_packet(8'h08, 8'h10, 8'h20);
    check("al_pv_cnt", 32'(pv_cnt - pv0), 32'd1);
    check("al_fe_cnt", 32'(fe_cnt - fe0), 32'd0);
    check("al_btn", 32'(bus.buttons), 32'h0);
    check("al_dx",  32'(bus.dx), 32'h010);
    check("al_dy",  32'(bus.dy), 32'h020);

    // Overflow flags pass straight through
    send_packet(8'hC8, 8'h00, 8'hFF);
    check("ov_ovx", 32'(bus.overflow_x), 32'd1);
    check("ov_ovy", 32'(bus.overflow_y), 32'd1);
    check("ov_dx",  32'(bus.dx), 32'h000);
    check("ov_dy",  32'(bus.dy), 32'h0FF);

    // 3-cycle glitches: idle and mid-frame
    fall0 = fall_cnt; pv0 = pv_cnt; fe0 = fe_cnt;
    bus.ps2_clk = 1'b0;
    idle(3);
    bus.ps2_clk = 1'b1;
    idle(50);
    check("gl_idle_fall", 32'(fall_cnt - fall0), 32'd0);
    fall0 = fall_cnt;
    send_byte(8'h1C, 1'b0, 3);
    send_byte(8'h03);
    send_byte(8'h04);
    check("gl_fall_cnt", 32'(fall_cnt - fall0), 32'd33);
    check("gl_pv_cnt", 32'(pv_cnt - pv0), 32'd1);
    check("gl_fe_cnt", 32'(fe_cnt - fe0), 32'd0);
    check("gl_btn", 32'(bus.buttons), 32'h4);
    check("gl_dx",  32'(bus.dx), 32'h103);
    check("gl_dy",  32'(bus.dy), 32'h004);

    // Inter-byte timeout resets the packet index without an error
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_byte(8'h08);
    idle(TMO + 10);
    check("to_fe_cnt", 32'(fe_cnt - fe0), 32'd0);
    send_packet(8'h09, 8'h01, 8'h02);
    check("to_pv_cnt", 32'(pv_cnt - pv0), 32'd1);
    check("to_btn", 32'(bus.buttons), 32'h1);
    check("to_dx",  32'(bus.dx), 32'h001);
    check("to_dy",  32'(bus.dy), 32'h002);

    // Reset mid-packet discards partial state
    send_packet(8'hC9, 8'h33, 8'h44);
    send_byte(8'h09);
    send_byte(8'h01, 1'b0, -1, 5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mr_btn", 32'(bus.buttons), 32'd0);
    check("mr_dx",  32'(bus.dx), 32'd0);
    check("mr_dy",  32'(bus.dy), 32'd0);
    check("mr_ovx", 32'(bus.overflow_x), 32'd0);
    check("mr_ovy", 32'(bus.overflow_y), 32'd0);
    idle(100);
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_packet(8'h09, 8'h01, 8'h02);
    check("mr_pv_cnt", 32'(pv_cnt - pv0), 32'd1);
    check("mr_fe_cnt", 32'(fe_cnt - fe0), 32'd0);
    check("mr_btn2", 32'(bus.buttons), 32'h1);
    check("mr_dx2",  32'(bus.dx), 32'h001);
    check("mr_dy2",  32'(bus.dy), 32'h002);

    check("pv_fe_overlap", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
